outerprodrc_drain: RTL and testbench
====================================

// Module: outerprodrc_drain
// PURPOSE
//  Run controller and result reader for the unary outer-product accumulator array.
//  - Clears the array, then enables it for CYCLES cycles.
//  - Snapshots all ROWNUM*COLNUM sign-magnitude accumulators.
//  - Streams them out one element per valid/ready handshake, row-major.
//  - Sits between the array and the downstream binary datapath/writeback.
// PARAMETERS
//  ROWNUM      4    rows in array
//  COLNUM      4    columns in array
//  OUTBITWIDTH 16   per-element width; MSB = sign, [OUTBITWIDTH-2:0] = magnitude
//  CYCLES      128  enable cycles per run (2^(BITWIDTH-1) for BITWIDTH=8); >=1
// PORTS
//  iClk      in   1                        clock; all logic on posedge
//  iRst      in   1                        synchronous reset, active-high
//  iStart    in   1                        start a run; honoured only in IDLE
//  oBusy     out  1                        high in every state except IDLE
//  oClr      out  1                        drives array iClr
//  oEn       out  1                        drives array iEn
//  iArrData  in   ROWNUM*COLNUM*OUTBITWIDTH  array accumulator outputs
//  oData     out  OUTBITWIDTH              current element
//  oValid    out  1                        oData/oIdx/oLast valid
//  iReady    in   1                        downstream accepts when oValid&iReady
//  oIdx      out  $clog2(ROWNUM*COLNUM)    element index k = i*COLNUM+j
//  oLast     out  1                        high with oValid when k == ROWNUM*COLNUM-1
//  oDone     out  1                        one-cycle pulse after last handshake
// BEHAVIOUR
//  Reset and outputs
//  - Reset: state=IDLE, counters=0, snapshot=0; every output 0.
//  - Reset wins over all other inputs, including mid-run.
//  - All outputs are Moore, decoded from registers; no input-to-output combinational path.
//  FSM: IDLE -> CLR -> RUN -> SNAP -> DRAIN -> IDLE
//  - IDLE:  iStart=1 -> CLR. oBusy=0.
//  - CLR:   oClr=1 for exactly 1 cycle; cycle counter <= 0 -> RUN.
//  - RUN:   oEn=1 for exactly CYCLES consecutive cycles -> SNAP.
//  - SNAP:  1 cycle, oEn=0. Array has absorbed its last enable edge.
//           Register snapshot <= iArrData; idx <= 0 -> DRAIN.
//  - DRAIN: oValid=1.
//           oData = element idx from bits [(idx+1)*OUTBITWIDTH-1 : idx*OUTBITWIDTH].
//           Handshake with idx < last: idx++.
//           Handshake with idx == last: oValid drops next cycle, oDone=1 for that cycle -> IDLE.
//  Handshake and latency
//  - oValid/oData/oIdx stay stable while iReady=0; no element skipped or repeated.
//  - iStart outside IDLE is ignored (not queued).
//  - iStart in the same cycle oDone is high is ignored (state not yet IDLE).
//  - Latency from iStart edge to first oValid: 1+1+CYCLES+1 = CYCLES+3 cycles.
//  - Snapshot is isolated from the array: iArrData changes during DRAIN have no effect on oData.
//  - oClr and oEn are never high in the same cycle.
// CONFIGURATION
//  OUTERPRODRC_DRAIN_TWOS_EN
//  - Defined: oData is two's complement, OUTBITWIDTH wide.
//    sign ? -{1'b0,mag} : {1'b0,mag}; sign=1 with mag=0 yields 0.
//    Conversion is combinational on the snapshot element; latency unchanged.
//  - Undefined: oData is the raw sign-magnitude snapshot element.
// STRUCTURE
//  - Shared package outerprodrc_pkg: state encoding localparams (IDLE,CLR,RUN,SNAP,DRAIN),
//    default ROWNUM/COLNUM/OUTBITWIDTH/CYCLES, element-slice width helpers.
//  - One sub-module: outerprodrc_sm2tc (OUTBITWIDTH-wide sign-magnitude -> two's complement).
//    Instantiated only under OUTERPRODRC_DRAIN_TWOS_EN.
// TESTING
//  Bench drives a behavioural array model (counts oEn cycles, clears on oClr). R=C=2, OBW=16, CYCLES=8.
//  1 Basic run: model elems {+5,-3,+0,-8}, iReady=1 -> first oValid 11 cycles after iStart.
//    oIdx 0..3, oLast on idx 3, oDone pulse next cycle.
//    Data = {0x0005,0x8003,0x0000,0x8008} raw; {5,-3,0,-8} with _TWOS_EN.
//  2 Backpressure: iReady low 3 cycles on idx 1 -> idx1 data held 4 cycles, all 4 elements delivered once.
//  3 oEn/oClr count: per run exactly 1 oClr cycle then 8 consecutive oEn cycles, never overlapping.
//  4 Ignored start: iStart pulsed in RUN and DRAIN -> no restart.
//    Exactly one oDone; oBusy drops right after it.
//  5 Reset mid-op: iRst in RUN cycle 4 -> next cycle all outputs 0, state IDLE.
//    A new iStart gives a full clean run.
//  6 Snapshot isolation: model changes iArrData to all 0xFFFF during DRAIN -> oData still snapshot values.
//    Also -0 (0x8000) -> 0x0000 with _TWOS_EN.

Source files
------------

// File: rtl/outerprodrc_pkg.sv
// Shared types and defaults for the outer-product array run controller / drain.
package outerprodrc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    SNAP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int DEF_ROWNUM      = 4;
  localparam int DEF_COLNUM      = 4;
  localparam int DEF_OUTBITWIDTH = 16;
  localparam int DEF_CYCLES      = 128;

  // Width of a counter/index that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

  function automatic int flat_width(input int rows, input int cols, input int w);
    return rows * cols * w;
  endfunction

endpackage

// File: rtl/outerprodrc_sm2tc.sv
// Sign-magnitude to two's-complement converter; a negative zero maps to 0.
module outerprodrc_sm2tc #(
  parameter int W = 16
) (
  input  logic [W-1:0] sm,
  output logic [W-1:0] tc
);

  logic [W-1:0] mag_ext;

  assign mag_ext = {1'b0, sm[W-2:0]};
  assign tc      = sm[W-1] ? (~mag_ext + W'(1)) : mag_ext;

endmodule

// File: rtl/outerprodrc_drain.sv
// Run controller and result reader for the unary outer-product array: clear, enable for
// CYCLES cycles, snapshot, then stream row-major. Define OUTERPRODRC_DRAIN_TWOS_EN for two's-complement output.
module outerprodrc_drain
  import outerprodrc_pkg::*;
#(
  parameter int ROWNUM      = DEF_ROWNUM,
  parameter int COLNUM      = DEF_COLNUM,
  parameter int OUTBITWIDTH = DEF_OUTBITWIDTH,
  parameter int CYCLES      = DEF_CYCLES
) (
  input  logic                                      iClk,
  input  logic                                      iRst,
  input  logic                                      iStart,
  output logic                                      oBusy,
  output logic                                      oClr,
  output logic                                      oEn,
  input  logic [flat_width(ROWNUM, COLNUM, OUTBITWIDTH)-1:0] iArrData,
  output logic [OUTBITWIDTH-1:0]                    oData,
  output logic                                      oValid,
  input  logic                                      iReady,
  output logic [idx_width(ROWNUM*COLNUM)-1:0]       oIdx,
  output logic                                      oLast,
  output logic                                      oDone
);

  localparam int NELEM = ROWNUM * COLNUM;
  localparam int IW    = idx_width(NELEM);
  localparam int CW    = idx_width(CYCLES);
  localparam int FW    = flat_width(ROWNUM, COLNUM, OUTBITWIDTH);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic                 done_reg, done_next;
  logic                 snap_load;
  logic [FW-1:0]        snap_reg;
  logic [OUTBITWIDTH-1:0] elem [NELEM];
  logic [OUTBITWIDTH-1:0] elem_sel;
  logic [OUTBITWIDTH-1:0] elem_out;
  logic                 valid;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      snap_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
      if (snap_load) snap_reg <= iArrData;
    end
  end

  // The DRAIN state lingers one extra cycle with done_reg set, so oDone is seen while still busy.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    snap_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iStart) state_next = CLR;
      end
      CLR: begin
        cnt_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == CW'(CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = SNAP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      SNAP: begin
        snap_load  = 1'b1;
        idx_next   = '0;
        state_next = DRAIN;
      end
      DRAIN: begin
        if (done_reg) begin
          idx_next   = '0;
          state_next = IDLE;
        end else if (iReady) begin
          if (idx_reg == IW'(NELEM - 1)) done_next = 1'b1;
          else                           idx_next  = idx_reg + IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
    assign elem[gi] = snap_reg[slice_lo(gi, OUTBITWIDTH) +: OUTBITWIDTH];
  end

  assign elem_sel = elem[idx_reg];

`ifdef OUTERPRODRC_DRAIN_TWOS_EN
  outerprodrc_sm2tc #(.W(OUTBITWIDTH)) u_sm2tc (
    .sm (elem_sel),
    .tc (elem_out)
  );
`else
  assign elem_out = elem_sel;
`endif

  assign valid  = (state_reg == DRAIN) && !done_reg;
  assign oBusy  = (state_reg != IDLE);
  assign oClr   = (state_reg == CLR);
  assign oEn    = (state_reg == RUN);
  assign oValid = valid;
  assign oDone  = done_reg;
  // Element fields are zeroed outside a valid beat so idle outputs match the reset picture.
  assign oData  = valid ? elem_out : '0;
  assign oIdx   = valid ? idx_reg : '0;
  assign oLast  = valid && (idx_reg == IW'(NELEM - 1));

endmodule

// File: tb/tb_outerprodrc_drain.sv
// Scoreboard bench for outerprodrc_drain with a behavioural 2x2 accumulator array model.
module tb_outerprodrc_drain;

  localparam int R = 2, C = 2, OBW = 16, CYC = 8, N = R * C;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            ready = 1'b0;
  logic            busy, clr, en, valid, last, done;
  logic [N*OBW-1:0] arr_data;
  logic [OBW-1:0]  data;
  logic [1:0]      idx;

  int  checks = 0;
  int  errors = 0;
  int  mcnt = 0;
  bit  clobber = 1'b0;
  int  tmag [N];
  bit  tsign [N];

  typedef struct {
    logic [OBW-1:0] data;
    logic [1:0]     idx;
    logic           last;
  } exp_t;
  exp_t q [$];

  always #5 clk = ~clk;

  outerprodrc_drain #(.ROWNUM(R), .COLNUM(C), .OUTBITWIDTH(OBW), .CYCLES(CYC)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .oBusy(busy), .oClr(clr), .oEn(en),
    .iArrData(arr_data), .oData(data), .oValid(valid), .iReady(ready),
    .oIdx(idx), .oLast(last), .oDone(done)
  );

  // Array model: counts enable cycles, clears on oClr, saturates each element at its target.
  always @(posedge clk) begin
    if (clr)     mcnt <= 0;
    else if (en) mcnt <= mcnt + 1;
  end

  always_comb begin
    arr_data = '0;
    for (int k = 0; k < N; k++) begin
      if (clobber) arr_data[k*OBW +: OBW] = 16'hFFFF;
      else arr_data[k*OBW +: OBW] = {tsign[k], 15'((mcnt < tmag[k]) ? mcnt : tmag[k])};
    end
  end

  function automatic logic [OBW-1:0] exp_data(input int k);
`ifdef OUTERPRODRC_DRAIN_TWOS_EN
    return tsign[k] ? 16'(-tmag[k]) : 16'(tmag[k]);
`else
    return {tsign[k], 15'(tmag[k])};
`endif
  endfunction

  task automatic set_targets(input int m0, m1, m2, m3, input bit s0, s1, s2, s3);
    tmag[0] = m0; tmag[1] = m1; tmag[2] = m2; tmag[3] = m3;
    tsign[0] = s0; tsign[1] = s1; tsign[2] = s2; tsign[3] = s3;
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.data = exp_data(k);
      e.idx  = 2'(k);
      e.last = (k == N - 1);
      q.push_back(e);
    end
  endtask

  // Pulses iStart and waits for the first oValid, tallying oClr/oEn activity on the way.
  task automatic start_run(input bit poke_run, output int lat, output int clr_n,
                           output int en_n, output int en_rises, output int overlap);
    bit en_prev = 1'b0;
    lat = 0; clr_n = 0; en_n = 0; en_rises = 0; overlap = 0;
    start = 1'b1;
    do begin
      @(posedge clk); lat++;
      #1 start = poke_run && (lat == 5);
      @(negedge clk);
      if (clr) clr_n++;
      if (en) en_n++;
      if (en && !en_prev) en_rises++;
      if (clr && en) overlap++;
      en_prev = en;
    end while (!valid && lat < 60);
    start = 1'b0;
  endtask

  // Scoreboard consumer: each beat is compared with the queue head; pops on handshake.
  task automatic drain(input int stall_idx, input int stall_len, input bit poke_drain,
                       input bit poke_done, input bit do_clobber, output int held);
    int stalled = 0, cyc = 0;
    exp_t e;
    held = 0;
    while (q.size() > 0 && cyc < 100) begin
      e = q[0];
      checks++;
      if (valid !== 1'b1 || data !== e.data || idx !== e.idx || last !== e.last) begin
        errors++;
        $display("FAIL beat idx%0d: valid=%b data=%h idx=%0d last=%b expected valid=1 data=%h idx=%0d last=%b",
                 e.idx, valid, data, idx, last, e.data, e.idx, e.last);
      end
      if (e.idx == 2'(stall_idx)) held++;
      ready = !(e.idx == 2'(stall_idx) && stalled < stall_len);
      if (!ready) stalled++;
      else void'(q.pop_front());
      $display("beat idx=%0d data=%h ready=%b", idx, data, ready);
      @(posedge clk);
      #1 start = poke_drain && (cyc == 0);
      if (do_clobber) clobber = 1'b1;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) begin
      errors++;
      $display("FAIL drain_timeout: %0d elements left, required 0", q.size());
      q.delete();
    end
    ready = 1'b0;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1 0 1", done, valid, busy);
    end
    start = poke_done;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b required 0 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b done=%b required 0 0", busy, done);
    end
    clobber = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, clr, en, valid, last, done} !== 6'b0 || data !== 16'h0 || idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy%b clr%b en%b valid%b last%b done%b data=%h idx=%0d required all 0",
               busy, clr, en, valid, last, done, data, idx);
    end
    $display("reset: outputs busy=%b valid=%b data=%h", busy, valid, data);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_run(input string name, input int lat, clr_n, en_n, en_rises, overlap);
    checks++;
    if (lat != CYC + 3) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, CYC + 3);
    end
    checks++;
    if (clr_n != 1 || en_n != CYC || en_rises != 1 || overlap != 0) begin
      errors++;
      $display("FAIL %s clr_en: clr=%0d en=%0d en_bursts=%0d overlap=%0d required 1 %0d 1 0",
               name, clr_n, en_n, en_rises, overlap, CYC);
    end
    $display("%s: latency=%0d clr=%0d en=%0d", name, lat, clr_n, en_n);
  endtask

  task automatic test_basic();
    int lat, cn, en_n, er, ov, held;
    set_targets(5, 3, 0, 8, 1'b0, 1'b1, 1'b0, 1'b1);
    start_run(1'b0, lat, cn, en_n, er, ov);
    check_run("basic", lat, cn, en_n, er, ov);
    drain(-1, 0, 1'b0, 1'b0, 1'b0, held);
  endtask

  task automatic test_backpressure();
    int lat, cn, en_n, er, ov, held;
    set_targets(1, 7, 2, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    start_run(1'b0, lat, cn, en_n, er, ov);
    check_run("backpressure", lat, cn, en_n, er, ov);
    drain(1, 3, 1'b0, 1'b0, 1'b0, held);
    checks++;
    if (held != 4) begin
      errors++;
      $display("FAIL stall_hold: idx1 seen %0d cycles required 4", held);
    end
  endtask

  task automatic test_ignored_start();
    int lat, cn, en_n, er, ov, held;
    set_targets(6, 6, 1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    start_run(1'b1, lat, cn, en_n, er, ov);
    check_run("ignored_start", lat, cn, en_n, er, ov);
    drain(-1, 0, 1'b1, 1'b1, 1'b0, held);
  endtask

  task automatic test_reset_mid_run();
    int lat, cn, en_n, er, ov, held, ens = 0, cyc = 0;
    start = 1'b1;
    do begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); cyc++;
      if (en) ens++;
    end while (ens < 4 && cyc < 40);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, clr, en, valid, last, done} !== 6'b0 || data !== 16'h0 || idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: busy%b clr%b en%b valid%b last%b done%b data=%h required all 0",
               busy, clr, en, valid, last, done, data);
    end
    $display("mid_reset: busy=%b en=%b after %0d enables", busy, en, ens);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    set_targets(2, 4, 8, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    start_run(1'b0, lat, cn, en_n, er, ov);
    check_run("post_reset", lat, cn, en_n, er, ov);
    drain(-1, 0, 1'b0, 1'b0, 1'b0, held);
  endtask

  task automatic test_snapshot_isolation();
    int lat, cn, en_n, er, ov, held;
    set_targets(0, 7, 1, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    start_run(1'b0, lat, cn, en_n, er, ov);
    check_run("snapshot", lat, cn, en_n, er, ov);
    drain(2, 1, 1'b0, 1'b0, 1'b1, held);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_run();
    test_snapshot_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
